// File: rtl/axi_sram_responder.sv
// axi_sram_responder: single-outstanding AXI4 subordinate backed by a word-addressed SRAM
module axi_sram_responder #(
    parameter int unsigned AxiIdWidth   = 4,
    parameter int unsigned AxiAddrWidth = 64,
    parameter int unsigned AxiDataWidth = 64,
    parameter int unsigned MemWords     = 4096,
    parameter logic [63:0] BaseAddr     = 64'h8000_0000
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      aw_valid_i,
    output logic                      aw_ready_o,
    input  logic [AxiIdWidth-1:0]     aw_id_i,
    input  logic [AxiAddrWidth-1:0]   aw_addr_i,
    input  logic [7:0]                aw_len_i,
    input  logic [2:0]                aw_size_i,
    input  logic [1:0]                aw_burst_i,
    input  logic [5:0]                aw_atop_i,
    input  logic                      w_valid_i,
    output logic                      w_ready_o,
    input  logic [AxiDataWidth-1:0]   w_data_i,
    input  logic [AxiDataWidth/8-1:0] w_strb_i,
    input  logic                      w_last_i,
    output logic                      b_valid_o,
    input  logic                      b_ready_i,
    output logic [AxiIdWidth-1:0]     b_id_o,
    output logic [1:0]                b_resp_o,
    input  logic                      ar_valid_i,
    output logic                      ar_ready_o,
    input  logic [AxiIdWidth-1:0]     ar_id_i,
    input  logic [AxiAddrWidth-1:0]   ar_addr_i,
    input  logic [7:0]                ar_len_i,
    input  logic [2:0]                ar_size_i,
    input  logic [1:0]                ar_burst_i,
    output logic                      r_valid_o,
    input  logic                      r_ready_i,
    output logic [AxiIdWidth-1:0]     r_id_o,
    output logic [AxiDataWidth-1:0]   r_data_o,
    output logic [1:0]                r_resp_o,
    output logic                      r_last_o
);
    typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_t;
    localparam int unsigned IdxW = $clog2(MemWords);
    localparam logic [AxiAddrWidth-1:0] Span = AxiAddrWidth'(MemWords) << 3;
    state_t                    state;
    logic                      last_was_write, err, err_w, err_r;
    logic                      in_range, grant_w, grant_r, wr_en, at_last;
    logic [AxiIdWidth-1:0]     id;
    logic [AxiAddrWidth-1:0]   addr, off, next_addr;
    logic [7:0]                len;
    logic [2:0]                size;
    logic [1:0]                burst, resp, beat_resp, wr_resp;
    logic [8:0]                cnt;
    logic [IdxW-1:0]           idx;
    logic [AxiDataWidth-1:0]   mem [MemWords];

    // Address decode, arbitration and per-beat response; numeric max of resp codes gives DECERR > SLVERR > OKAY
    always_comb begin
        off       = addr - AxiAddrWidth'(BaseAddr);
        in_range  = off < Span;
        idx       = off[IdxW+2:3];
        next_addr = (burst == 2'b01) ? addr + (AxiAddrWidth'(1) << size) : addr;
        at_last   = cnt == {1'b0, len};
        err_w     = aw_size_i > 3'd3 || aw_burst_i[1] || |aw_atop_i;
        err_r     = ar_size_i > 3'd3 || ar_burst_i[1];
        grant_w   = state == IDLE && aw_valid_i && (!ar_valid_i || !last_was_write);
        grant_r   = state == IDLE && ar_valid_i && !grant_w;
        wr_en     = state == WRITE && w_valid_i && !err && in_range && cnt <= {1'b0, len};
        beat_resp = in_range ? resp : 2'b11;
        wr_resp   = (w_last_i && !at_last && beat_resp < 2'b10) ? 2'b10 : beat_resp;
    end

    assign aw_ready_o = grant_w;
    assign ar_ready_o = grant_r;
    assign w_ready_o  = state == WRITE;
    assign b_valid_o  = state == WRESP;
    assign b_id_o     = id;
    assign b_resp_o   = (state == WRESP) ? resp : 2'b00;
    assign r_valid_o  = state == READ;
    assign r_id_o     = id;
    assign r_data_o   = (state == READ && !err && in_range) ? mem[idx] : '0;
    assign r_resp_o   = (state == READ) ? (in_range ? {err, 1'b0} : 2'b11) : 2'b00;
    assign r_last_o   = state == READ && at_last;

    // Transaction FSM: capture request, walk the beats, emit the response, track fairness
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state          <= IDLE;
            last_was_write <= 1'b0;
            id             <= '0;
            addr           <= '0;
            len            <= '0;
            size           <= '0;
            burst          <= '0;
            cnt            <= '0;
            err            <= 1'b0;
            resp           <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_w) begin
                        state <= WRITE;
                        id    <= aw_id_i;
                        addr  <= aw_addr_i;
                        len   <= aw_len_i;
                        size  <= aw_size_i;
                        burst <= aw_burst_i;
                        cnt   <= '0;
                        err   <= err_w;
                        resp  <= {err_w, 1'b0};
                    end else if (grant_r) begin
                        state <= READ;
                        id    <= ar_id_i;
                        addr  <= ar_addr_i;
                        len   <= ar_len_i;
                        size  <= ar_size_i;
                        burst <= ar_burst_i;
                        cnt   <= '0;
                        err   <= err_r;
                    end
                end
                WRITE: begin
                    if (w_valid_i) begin
                        addr  <= next_addr;
                        cnt   <= cnt + 9'(!cnt[8]);
                        resp  <= wr_resp;
                        state <= w_last_i ? WRESP : WRITE;
                    end
                end
                WRESP: begin
                    if (b_ready_i) begin
                        state          <= IDLE;
                        last_was_write <= 1'b1;
                    end
                end
                default: begin
                    if (r_ready_i) begin
                        addr <= next_addr;
                        cnt  <= cnt + 9'd1;
                        if (at_last) begin
                            state          <= IDLE;
                            last_was_write <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    // Byte-lane SRAM write; the array itself is never reset
    always_ff @(posedge clk_i) begin
        if (wr_en)
            for (int b = 0; b < AxiDataWidth / 8; b++)
                if (w_strb_i[b]) mem[idx][8*b +: 8] <= w_data_i[8*b +: 8];
    end
endmodule

// File: tb/tb_axi_sram_responder.sv
// tb_axi_sram_responder: directed scenarios with hand-computed expectations for axi_sram_responder
module tb_axi_sram_responder;
    localparam logic [63:0] B = 64'h8000_0000;
    logic        clk = 1'b0, rst_ni = 1'b0;
    logic        aw_valid = 0, aw_ready, w_valid = 0, w_ready, w_last = 0;
    logic        b_valid, b_ready = 0, ar_valid = 0, ar_ready, r_valid, r_ready = 0, r_last;
    logic [3:0]  aw_id = 0, ar_id = 0, b_id, r_id;
    logic [63:0] aw_addr = 0, ar_addr = 0, w_data = 0, r_data;
    logic [7:0]  aw_len = 0, ar_len = 0, w_strb = 0;
    logic [2:0]  aw_size = 3, ar_size = 3;
    logic [1:0]  aw_burst = 1, ar_burst = 1, b_resp, r_resp;
    logic [5:0]  aw_atop = 0;
    int          vecs = 0, miscmp = 0;

    always #5 clk = ~clk;

    axi_sram_responder dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_id_i(aw_id), .aw_addr_i(aw_addr),
        .aw_len_i(aw_len), .aw_size_i(aw_size), .aw_burst_i(aw_burst), .aw_atop_i(aw_atop),
        .w_valid_i(w_valid), .w_ready_o(w_ready), .w_data_i(w_data), .w_strb_i(w_strb), .w_last_i(w_last),
        .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp),
        .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_id_i(ar_id), .ar_addr_i(ar_addr),
        .ar_len_i(ar_len), .ar_size_i(ar_size), .ar_burst_i(ar_burst),
        .r_valid_o(r_valid), .r_ready_i(r_ready), .r_id_o(r_id), .r_data_o(r_data),
        .r_resp_o(r_resp), .r_last_o(r_last)
    );

    // Drivers: all enter and leave 1 time unit after a rising edge
    task automatic do_aw(input logic [3:0] id, input logic [63:0] a, input logic [7:0] l,
                         input logic [1:0] bu, input logic [5:0] at);
        aw_id = id; aw_addr = a; aw_len = l; aw_size = 3; aw_burst = bu; aw_atop = at; aw_valid = 1; #1;
        for (int n = 0; n < 20 && !aw_ready; n++) begin @(posedge clk); #1; end
        vecs++; if (aw_ready !== 1'b1) begin miscmp++; $display("FAIL aw_handshake: aw_ready=%b want 1", aw_ready); end
        @(posedge clk); #1; aw_valid = 0;
    endtask

    task automatic do_ar(input logic [3:0] id, input logic [63:0] a, input logic [7:0] l, input logic [1:0] bu);
        ar_id = id; ar_addr = a; ar_len = l; ar_size = 3; ar_burst = bu; ar_valid = 1; #1;
        for (int n = 0; n < 20 && !ar_ready; n++) begin @(posedge clk); #1; end
        vecs++; if (ar_ready !== 1'b1) begin miscmp++; $display("FAIL ar_handshake: ar_ready=%b want 1", ar_ready); end
        @(posedge clk); #1; ar_valid = 0;
    endtask

    task automatic do_w(input logic [63:0] d, input logic [7:0] s, input logic l);
        w_data = d; w_strb = s; w_last = l; w_valid = 1; #1;
        for (int n = 0; n < 20 && !w_ready; n++) begin @(posedge clk); #1; end
        vecs++; if (w_ready !== 1'b1) begin miscmp++; $display("FAIL w_handshake: w_ready=%b want 1", w_ready); end
        @(posedge clk); #1; w_valid = 0; w_last = 0;
    endtask

    task automatic b_accept();
        b_ready = 1; @(posedge clk); #1; b_ready = 0;
    endtask

    task automatic test_reset();
        rst_ni = 0; repeat (2) @(posedge clk); #1;
        vecs++; if ({aw_ready, ar_ready, w_ready, b_valid, r_valid, r_last} !== 6'b0) begin miscmp++; $display("FAIL reset_flags: got %b want 000000", {aw_ready, ar_ready, w_ready, b_valid, r_valid, r_last}); end
        vecs++; if ({b_resp, r_resp, b_id, r_id} !== 12'h0) begin miscmp++; $display("FAIL reset_resp_id: got %h want 000", {b_resp, r_resp, b_id, r_id}); end
        vecs++; if (r_data !== 64'h0) begin miscmp++; $display("FAIL reset_rdata: got %h want 0", r_data); end
        rst_ni = 1; @(posedge clk); #1;
    endtask

    task automatic test_burst();
        do_aw(4'd5, B, 8'd3, 2'b01, 6'h0);
        vecs++; if (w_ready !== 1'b1) begin miscmp++; $display("FAIL burst_wready: got %b want 1", w_ready); end
        for (int i = 0; i < 4; i++) do_w(64'h11 * 64'(i + 1), 8'hFF, i == 3);
        vecs++; if ({b_valid, b_id, b_resp} !== {1'b1, 4'd5, 2'b00}) begin miscmp++; $display("FAIL burst_b: got %h want %h", {b_valid, b_id, b_resp}, {1'b1, 4'd5, 2'b00}); end
        b_accept();
        vecs++; if (b_valid !== 1'b0) begin miscmp++; $display("FAIL burst_b_drop: got %b want 0", b_valid); end
        do_ar(4'd6, B, 8'd3, 2'b01);
        vecs++; if (r_id !== 4'd6) begin miscmp++; $display("FAIL burst_rid: got %h want 6", r_id); end
        r_ready = 1;
        for (int i = 0; i < 4; i++) begin
            vecs++; if ({r_valid, r_last, r_resp, r_data} !== {1'b1, i == 3, 2'b00, 64'h11 * 64'(i + 1)}) begin
                miscmp++; $display("FAIL burst_read beat %0d: got %h want %h", i, {r_valid, r_last, r_resp, r_data}, {1'b1, i == 3, 2'b00, 64'h11 * 64'(i + 1)}); end
            @(posedge clk); #1;
        end
        r_ready = 0;
        vecs++; if (r_valid !== 1'b0) begin miscmp++; $display("FAIL burst_r_drop: got %b want 0", r_valid); end
    endtask

    task automatic test_partial_strobe();
        do_aw(4'd1, B + 64'h100, 8'd0, 2'b01, 6'h0); do_w(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1); b_accept();
        do_aw(4'd1, B + 64'h100, 8'd0, 2'b01, 6'h0); do_w(64'hAABB_CCDD_EEFF_0011, 8'h0F, 1'b1);
        vecs++; if ({b_valid, b_resp} !== 3'b100) begin miscmp++; $display("FAIL strobe_b: got %b want 100", {b_valid, b_resp}); end
        b_accept();
        do_ar(4'd2, B + 64'h100, 8'd0, 2'b01);
        vecs++; if ({r_valid, r_last, r_resp, r_data} !== {4'b1100, 64'hFFFF_FFFF_EEFF_0011}) begin
            miscmp++; $display("FAIL strobe_read: got %h want %h", {r_valid, r_last, r_resp, r_data}, {4'b1100, 64'hFFFF_FFFF_EEFF_0011}); end
        r_ready = 1; @(posedge clk); #1; r_ready = 0;
    endtask

    task automatic test_arbitration();
        rst_ni = 0; @(posedge clk); #1; rst_ni = 1;
        aw_id = 3; aw_addr = B + 64'h200; aw_len = 0; aw_size = 3; aw_burst = 1; aw_atop = 0;
        ar_id = 4; ar_addr = B + 64'h200; ar_len = 0; ar_size = 3; ar_burst = 1;
        aw_valid = 1; ar_valid = 1; #1;
        vecs++; if ({aw_ready, ar_ready} !== 2'b10) begin miscmp++; $display("FAIL arb_tie1: got %b want 10", {aw_ready, ar_ready}); end
        @(posedge clk); #1; aw_valid = 0;
        vecs++; if ({ar_ready, w_ready} !== 2'b01) begin miscmp++; $display("FAIL arb_busy: got %b want 01", {ar_ready, w_ready}); end
        do_w(64'h77, 8'hFF, 1'b1); b_accept();
        aw_valid = 1; #1;
        vecs++; if ({aw_ready, ar_ready} !== 2'b01) begin miscmp++; $display("FAIL arb_tie2: got %b want 01", {aw_ready, ar_ready}); end
        @(posedge clk); #1; aw_valid = 0; ar_valid = 0;
        vecs++; if ({r_valid, r_id, r_data} !== {1'b1, 4'd4, 64'h77}) begin miscmp++; $display("FAIL arb_read: got %h want %h", {r_valid, r_id, r_data}, {1'b1, 4'd4, 64'h77}); end
        r_ready = 1; @(posedge clk); #1; r_ready = 0;
        aw_valid = 1; ar_valid = 1; #1;
        vecs++; if ({aw_ready, ar_ready} !== 2'b10) begin miscmp++; $display("FAIL arb_tie3: got %b want 10", {aw_ready, ar_ready}); end
        @(posedge clk); #1; aw_valid = 0; ar_valid = 0;
        do_w(64'h88, 8'hFF, 1'b1); b_accept();
    endtask

    task automatic test_boundary();
        do_aw(4'd7, B + 64'h7FF8, 8'd0, 2'b01, 6'h0); do_w(64'h1234_5678_9ABC_DEF0, 8'hFF, 1'b1); b_accept();
        do_aw(4'd7, B + 64'h8000, 8'd0, 2'b01, 6'h0); do_w(64'h1, 8'hFF, 1'b1);
        vecs++; if ({b_valid, b_resp} !== 3'b111) begin miscmp++; $display("FAIL oob_write_b: got %b want 111", {b_valid, b_resp}); end
        b_accept();
        do_ar(4'd8, B + 64'h7FF8, 8'd1, 2'b01);
        r_ready = 1;
        vecs++; if ({r_valid, r_last, r_resp, r_data} !== {4'b1000, 64'h1234_5678_9ABC_DEF0}) begin
            miscmp++; $display("FAIL edge_beat0: got %h want %h", {r_valid, r_last, r_resp, r_data}, {4'b1000, 64'h1234_5678_9ABC_DEF0}); end
        @(posedge clk); #1;
        vecs++; if ({r_valid, r_last, r_resp, r_data} !== {4'b1111, 64'h0}) begin
            miscmp++; $display("FAIL edge_beat1: got %h want %h", {r_valid, r_last, r_resp, r_data}, {4'b1111, 64'h0}); end
        @(posedge clk); #1; r_ready = 0;
    endtask

    task automatic test_errors();
        do_aw(4'd9, B + 64'h300, 8'd0, 2'b01, 6'h0); do_w(64'h5555, 8'hFF, 1'b1); b_accept();
        do_aw(4'd9, B + 64'h300, 8'd1, 2'b01, 6'h20); do_w(64'hDEAD, 8'hFF, 1'b0); do_w(64'hBEEF, 8'hFF, 1'b1);
        vecs++; if ({b_valid, b_id, b_resp} !== {1'b1, 4'd9, 2'b10}) begin miscmp++; $display("FAIL atop_b: got %h want %h", {b_valid, b_id, b_resp}, {1'b1, 4'd9, 2'b10}); end
        b_accept();
        do_ar(4'd9, B + 64'h300, 8'd0, 2'b01);
        vecs++; if ({r_resp, r_data} !== {2'b00, 64'h5555}) begin miscmp++; $display("FAIL atop_mem: got %h want %h", {r_resp, r_data}, {2'b00, 64'h5555}); end
        r_ready = 1; @(posedge clk); #1; r_ready = 0;
        do_ar(4'd10, B, 8'd1, 2'b10);
        r_ready = 1;
        for (int i = 0; i < 2; i++) begin
            vecs++; if ({r_valid, r_last, r_resp, r_data} !== {1'b1, i == 1, 2'b10, 64'h0}) begin
                miscmp++; $display("FAIL wrap_read beat %0d: got %h want %h", i, {r_valid, r_last, r_resp, r_data}, {1'b1, i == 1, 2'b10, 64'h0}); end
            @(posedge clk); #1;
        end
        r_ready = 0;
        vecs++; if (r_valid !== 1'b0) begin miscmp++; $display("FAIL wrap_done: got %b want 0", r_valid); end
        do_aw(4'd11, B + 64'h400, 8'd3, 2'b01, 6'h0); do_w(64'h1, 8'hFF, 1'b0); do_w(64'h2, 8'hFF, 1'b1);
        vecs++; if ({b_valid, b_id, b_resp} !== {1'b1, 4'd11, 2'b10}) begin miscmp++; $display("FAIL early_last_b: got %h want %h", {b_valid, b_id, b_resp}, {1'b1, 4'd11, 2'b10}); end
        b_accept();
    endtask

    task automatic test_reset_mid_read();
        do_ar(4'd12, B, 8'd3, 2'b01);
        vecs++; if (r_valid !== 1'b1) begin miscmp++; $display("FAIL midrd_valid: got %b want 1", r_valid); end
        rst_ni = 0; @(posedge clk); #1; rst_ni = 1;
        vecs++; if ({r_valid, r_last, r_id} !== 6'h0) begin miscmp++; $display("FAIL midrd_abort: got %h want 00", {r_valid, r_last, r_id}); end
        @(posedge clk); #1;
        aw_valid = 1; #1;
        vecs++; if ({aw_ready, r_valid} !== 2'b10) begin miscmp++; $display("FAIL midrd_idle: got %b want 10", {aw_ready, r_valid}); end
        aw_valid = 0; @(posedge clk); #1;
        do_ar(4'd13, B, 8'd0, 2'b01);
        vecs++; if (r_data !== 64'h11) begin miscmp++; $display("FAIL midrd_mem_kept: got %h want 11", r_data); end
        r_ready = 1; @(posedge clk); #1; r_ready = 0;
    endtask

    initial begin
        test_reset();
        test_burst();
        test_partial_strobe();
        test_arbitration();
        test_boundary();
        test_errors();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end

    // Absolute time bound so the run cannot hang
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
